// File: rtl/cache_mem_responder.sv
// Memory responder: unified word array shared by the icache and dcache cmd/rsp ports.
// Features: programmable read latency, outstanding-read caps, periodic stall, byte-strobed writes, access counters.
module cache_mem_responder #(
  parameter int ADDR_W          = 64,
  parameter int DATA_W          = 64,
  parameter int IDATA_W         = 32,
  parameter int DEPTH_LOG2      = 17,
  parameter int RD_LATENCY      = 1,
  parameter int MAX_OUTSTANDING = 4,
  parameter int STALL_PERIOD    = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                icache_cmd_valid,
  output logic                icache_cmd_ready,
  input  logic [ADDR_W-1:0]   icache_cmd_payload_addr,
  output logic                icache_rsp_valid,
  output logic [IDATA_W-1:0]  icache_rsp_payload_data,
  input  logic                dcache_cmd_valid,
  output logic                dcache_cmd_ready,
  input  logic [ADDR_W-1:0]   dcache_cmd_payload_addr,
  input  logic                dcache_cmd_payload_wen,
  input  logic [DATA_W-1:0]   dcache_cmd_payload_wdata,
  input  logic [DATA_W/8-1:0] dcache_cmd_payload_wstrb,
  output logic                dcache_rsp_valid,
  output logic [DATA_W-1:0]   dcache_rsp_payload_data,
  output logic [31:0]         rd_cnt,
  output logic [31:0]         wr_cnt
);

  localparam int OFS   = $clog2(DATA_W / 8);
  localparam int IOFS  = $clog2(IDATA_W / 8);
  localparam int LANES = DATA_W / IDATA_W;
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int OW    = $clog2(MAX_OUTSTANDING + 1);
  localparam int SW    = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
  localparam int NB    = DATA_W / 8;

  logic [DATA_W-1:0] mem [0:(1<<DEPTH_LOG2)-1];

  logic [DEPTH_LOG2-1:0] i_idx, d_idx;
  logic [LW-1:0]         i_lane;
  logic [DATA_W-1:0]     i_word, d_word;
  logic [IDATA_W-1:0]    i_lane_data;

  assign i_idx  = icache_cmd_payload_addr[DEPTH_LOG2+OFS-1:OFS];
  assign d_idx  = dcache_cmd_payload_addr[DEPTH_LOG2+OFS-1:OFS];
  assign i_word = mem[i_idx];
  assign d_word = mem[d_idx];

  if (LANES > 1) begin : g_lane
    assign i_lane = icache_cmd_payload_addr[OFS-1:IOFS];
  end else begin : g_nolane
    assign i_lane = '0;
  end
  assign i_lane_data = i_word[i_lane*IDATA_W +: IDATA_W];

  // Aliasing high bits and sub-lane/sub-word bits are ignored by design.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{icache_cmd_payload_addr[ADDR_W-1:DEPTH_LOG2+OFS],
                              icache_cmd_payload_addr[IOFS-1:0],
                              dcache_cmd_payload_addr[ADDR_W-1:DEPTH_LOG2+OFS],
                              dcache_cmd_payload_addr[OFS-1:0]};

  logic [SW-1:0]            stall_cnt_q, stall_cnt_d;
  logic [OW-1:0]            i_out_q, i_out_d, d_out_q, d_out_d;
  logic [31:0]              rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
  logic [RD_LATENCY-1:0]    ipv_q, ipv_d, dpv_q, dpv_d;
  logic [IDATA_W-1:0]       ipd_q [RD_LATENCY];
  logic [IDATA_W-1:0]       ipd_d [RD_LATENCY];
  logic [DATA_W-1:0]        dpd_q [RD_LATENCY];
  logic [DATA_W-1:0]        dpd_d [RD_LATENCY];
  logic [RD_LATENCY:0]      iv_in, dv_in;
  logic [IDATA_W-1:0]       id_in [RD_LATENCY+1];
  logic [DATA_W-1:0]        dd_in [RD_LATENCY+1];

  logic stall, i_acc, d_acc, d_rd_acc, d_wr_acc;

  assign stall = (STALL_PERIOD != 0) && (stall_cnt_q == SW'(STALL_PERIOD - 1));
  // rst_n gates ready so nothing is accepted (or written) while reset is asserted.
  assign icache_cmd_ready = rst_n && !stall && (i_out_q < OW'(MAX_OUTSTANDING));
  assign dcache_cmd_ready = rst_n && !stall && (d_out_q < OW'(MAX_OUTSTANDING));

  assign i_acc    = icache_cmd_valid && icache_cmd_ready;
  assign d_acc    = dcache_cmd_valid && dcache_cmd_ready;
  assign d_rd_acc = d_acc && !dcache_cmd_payload_wen;
  assign d_wr_acc = d_acc && dcache_cmd_payload_wen;

  always_comb begin
    stall_cnt_d = '0;
    if (STALL_PERIOD != 0 && !stall) stall_cnt_d = stall_cnt_q + SW'(1);

    iv_in    = {ipv_q, i_acc};
    dv_in    = {dpv_q, d_rd_acc};
    id_in[0] = i_lane_data;
    dd_in[0] = d_word;
    for (int k = 0; k < RD_LATENCY; k++) begin
      id_in[k+1] = ipd_q[k];
      dd_in[k+1] = dpd_q[k];
    end
    ipv_d = iv_in[RD_LATENCY-1:0];
    dpv_d = dv_in[RD_LATENCY-1:0];
    for (int k = 0; k < RD_LATENCY; k++) begin
      ipd_d[k] = iv_in[k] ? id_in[k] : ipd_q[k];
      dpd_d[k] = dv_in[k] ? dd_in[k] : dpd_q[k];
    end

    // A slot frees on the edge that launches its response, so MAX_OUTSTANDING>=RD_LATENCY streams.
    i_out_d  = i_out_q + OW'(i_acc) - OW'(ipv_d[RD_LATENCY-1]);
    d_out_d  = d_out_q + OW'(d_rd_acc) - OW'(dpv_d[RD_LATENCY-1]);
    rd_cnt_d = rd_cnt_q + 32'(i_acc) + 32'(d_rd_acc);
    wr_cnt_d = wr_cnt_q + 32'(d_wr_acc);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      i_out_q     <= '0;
      d_out_q     <= '0;
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
      ipv_q       <= '0;
      dpv_q       <= '0;
      for (int k = 0; k < RD_LATENCY; k++) begin
        ipd_q[k] <= '0;
        dpd_q[k] <= '0;
      end
    end else begin
      stall_cnt_q <= stall_cnt_d;
      i_out_q     <= i_out_d;
      d_out_q     <= d_out_d;
      rd_cnt_q    <= rd_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      ipv_q       <= ipv_d;
      dpv_q       <= dpv_d;
      for (int k = 0; k < RD_LATENCY; k++) begin
        ipd_q[k] <= ipd_d[k];
        dpd_q[k] <= dpd_d[k];
      end
    end
  end

  // Array is never reset; same-edge reads sample the pre-write word.
  always_ff @(posedge clk) begin
    if (d_wr_acc) begin
      for (int b = 0; b < NB; b++) begin
        if (dcache_cmd_payload_wstrb[b]) mem[d_idx][b*8 +: 8] <= dcache_cmd_payload_wdata[b*8 +: 8];
      end
    end
  end

  assign icache_rsp_valid        = ipv_q[RD_LATENCY-1];
  assign icache_rsp_payload_data = ipd_q[RD_LATENCY-1];
  assign dcache_rsp_valid        = dpv_q[RD_LATENCY-1];
  assign dcache_rsp_payload_data = dpd_q[RD_LATENCY-1];
  assign rd_cnt                  = rd_cnt_q;
  assign wr_cnt                  = wr_cnt_q;

endmodule

// File: tb/tb_cache_mem_responder.sv
// Directed bench for cache_mem_responder: three instances (LAT1, LAT3/MAX2, LAT4/STALL4) share stimulus.
module tb_cache_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iv, dv, dwen;
  logic [63:0] ia, da, dwd;
  logic [7:0]  dws;

  logic        irdy_a, irv_a, drdy_a, drv_a;
  logic [31:0] ird_a, rdc_a, wrc_a;
  logic [63:0] drd_a;
  logic        irdy_b, irv_b, drdy_b, drv_b;
  logic [31:0] ird_b, rdc_b, wrc_b;
  logic [63:0] drd_b;
  logic        irdy_c, irv_c, drdy_c, drv_c;
  logic [31:0] ird_c, rdc_c, wrc_c;
  logic [63:0] drd_c;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cache_mem_responder dut_a (
    .clk(clk), .rst_n(rst_n),
    .icache_cmd_valid(iv), .icache_cmd_ready(irdy_a), .icache_cmd_payload_addr(ia),
    .icache_rsp_valid(irv_a), .icache_rsp_payload_data(ird_a),
    .dcache_cmd_valid(dv), .dcache_cmd_ready(drdy_a), .dcache_cmd_payload_addr(da),
    .dcache_cmd_payload_wen(dwen), .dcache_cmd_payload_wdata(dwd), .dcache_cmd_payload_wstrb(dws),
    .dcache_rsp_valid(drv_a), .dcache_rsp_payload_data(drd_a),
    .rd_cnt(rdc_a), .wr_cnt(wrc_a));

  cache_mem_responder #(.RD_LATENCY(3), .MAX_OUTSTANDING(2)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .icache_cmd_valid(iv), .icache_cmd_ready(irdy_b), .icache_cmd_payload_addr(ia),
    .icache_rsp_valid(irv_b), .icache_rsp_payload_data(ird_b),
    .dcache_cmd_valid(dv), .dcache_cmd_ready(drdy_b), .dcache_cmd_payload_addr(da),
    .dcache_cmd_payload_wen(dwen), .dcache_cmd_payload_wdata(dwd), .dcache_cmd_payload_wstrb(dws),
    .dcache_rsp_valid(drv_b), .dcache_rsp_payload_data(drd_b),
    .rd_cnt(rdc_b), .wr_cnt(wrc_b));

  cache_mem_responder #(.RD_LATENCY(4), .MAX_OUTSTANDING(4), .STALL_PERIOD(4)) dut_c (
    .clk(clk), .rst_n(rst_n),
    .icache_cmd_valid(iv), .icache_cmd_ready(irdy_c), .icache_cmd_payload_addr(ia),
    .icache_rsp_valid(irv_c), .icache_rsp_payload_data(ird_c),
    .dcache_cmd_valid(dv), .dcache_cmd_ready(drdy_c), .dcache_cmd_payload_addr(da),
    .dcache_cmd_payload_wen(dwen), .dcache_cmd_payload_wdata(dwd), .dcache_cmd_payload_wstrb(dws),
    .dcache_rsp_valid(drv_c), .dcache_rsp_payload_data(drd_c),
    .rd_cnt(rdc_c), .wr_cnt(wrc_c));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
  endtask

  logic        acc_at [0:14];
  int          idx_at [0:14];
  int          nacc, nrsp;
  logic        exp_rdy;

  initial begin
    rst_n = 1'b0; iv = 1'b0; dv = 1'b0; dwen = 1'b0;
    ia = '0; da = '0; dwd = '0; dws = '0;
    step();
    step();
    chk("rst_irdy_low", irdy_a, 0);
    chk("rst_drdy_low", drdy_a, 0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_irdy_a", irdy_a, 1);  chk("post_rst_drdy_a", drdy_a, 1);
    chk("post_rst_irv_a", irv_a, 0);    chk("post_rst_drv_a", drv_a, 0);
    chk("post_rst_ird_a", ird_a, 0);    chk("post_rst_drd_a", drd_a, 0);
    chk("post_rst_rdc_a", rdc_a, 0);    chk("post_rst_wrc_a", wrc_a, 0);
    chk("post_rst_irdy_b", irdy_b, 1);  chk("post_rst_drdy_b", drdy_b, 1);
    chk("post_rst_irv_b", irv_b, 0);    chk("post_rst_drv_b", drv_b, 0);
    chk("post_rst_ird_b", ird_b, 0);    chk("post_rst_drd_b", drd_b, 0);
    chk("post_rst_rdc_b", rdc_b, 0);    chk("post_rst_wrc_b", wrc_b, 0);
    chk("post_rst_irdy_c", irdy_c, 1);  chk("post_rst_drdy_c", drdy_c, 1);

    // preload word 0x10, then reset: counters clear, array keeps the word
    dv = 1; dwen = 1; da = 64'h80; dwd = 64'h1122334455667788; dws = 8'hFF;
    step();
    dv = 0; dwen = 0;
    chk("preload_wr_cnt", wrc_a, 1);
    chk("preload_no_rsp", drv_a, 0);
    do_reset();
    chk("reset_clears_wr_cnt", wrc_a, 0);

    // T1 icache lanes and aliasing
    iv = 1; ia = 64'h80;
    step();
    chk("t1_rsp0_valid", irv_a, 1);
    chk("t1_rsp0_data", ird_a, 32'h55667788);
    ia = 64'h84;
    step();
    chk("t1_rsp1_valid", irv_a, 1);
    chk("t1_rsp1_data", ird_a, 32'h11223344);
    ia = 64'h80 + (64'h1 << 20);
    step();
    chk("t1_alias_data", ird_a, 32'h55667788);
    iv = 0;
    chk("t1_rd_cnt", rdc_a, 3);
    step();
    chk("t1_rsp_drops", irv_a, 0);
    chk("t1_rsp_data_holds", ird_a, 32'h55667788);

    // T2 strobed write then dcache read
    dv = 1; dwen = 1; da = 64'h80; dwd = 64'hAAAAAAAAAAAAAAAA; dws = 8'h0F;
    step();
    chk("t2_no_wr_rsp", drv_a, 0);
    chk("t2_wr_cnt", wrc_a, 1);
    dwen = 0;
    step();
    dv = 0;
    chk("t2_rd_valid", drv_a, 1);
    chk("t2_rd_data", drd_a, 64'h11223344AAAAAAAA);
    chk("t2_rd_cnt", rdc_a, 4);

    // restore word, then T4 same-edge read/write collision
    dv = 1; dwen = 1; da = 64'h80; dwd = 64'h1122334455667788; dws = 8'hFF;
    step();
    iv = 1; ia = 64'h80; dwd = 64'h0;
    step();
    chk("t4_old_data_valid", irv_a, 1);
    chk("t4_old_data", ird_a, 32'h55667788);
    chk("t4_no_wr_rsp", drv_a, 0);
    chk("t4_wr_cnt", wrc_a, 3);
    dv = 0; dwen = 0;
    step();
    iv = 0;
    chk("t4_new_data", ird_a, 32'h0);

    // T3 on dut_b: LAT=3, MAX_OUT=2
    do_reset();
    for (int w = 0; w < 4; w++) begin
      dv = 1; dwen = 1; dws = 8'hFF; da = 64'h200 + 64'(8 * w);
      dwd = {32'hC0DE0000 + 32'(2 * w + 1), 32'hC0DE0000 + 32'(2 * w)};
      step();
    end
    dv = 0; dwen = 0;
    nacc = 0;
    for (int i = 0; i < 15; i++) begin
      exp_rdy = (i < 12) && (i % 3 != 2);
      iv = (i < 12);
      ia = 64'h200 + 64'(4 * nacc);
      if (i < 12) chk($sformatf("t3_ready_c%0d", i), irdy_b, exp_rdy);
      if (i >= 3) begin
        chk($sformatf("t3_rsp_valid_c%0d", i), irv_b, acc_at[i-3]);
        if (acc_at[i-3]) chk($sformatf("t3_rsp_data_c%0d", i), ird_b, 32'hC0DE0000 + 32'(idx_at[i-3]));
      end else begin
        chk($sformatf("t3_rsp_valid_c%0d", i), irv_b, 0);
      end
      acc_at[i] = exp_rdy;
      idx_at[i] = nacc;
      if (exp_rdy) nacc++;
      step();
    end
    iv = 0;
    chk("t3_rd_cnt", rdc_b, 8);

    // T5 on dut_c: STALL_PERIOD=4, both ports streaming reads
    do_reset();
    iv = 1; ia = 64'h80; dv = 1; dwen = 0; da = 64'h80;
    nrsp = 0;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("t5_irdy_c%0d", i), irdy_c, (i % 4 != 3));
      chk($sformatf("t5_drdy_c%0d", i), drdy_c, (i % 4 != 3));
      nrsp += int'(irv_c) + int'(drv_c);
      step();
    end
    iv = 0; dv = 0;
    for (int j = 0; j < 6; j++) begin
      nrsp += int'(irv_c) + int'(drv_c);
      step();
    end
    chk("t5_rd_cnt", rdc_c, 24);
    chk("t5_rsp_count", 64'(nrsp), 24);

    // T6 on dut_c: LAT=4, reads in flight dropped by reset, array survives
    do_reset();
    dv = 1; dwen = 1; da = 64'h100; dwd = 64'hDEADBEEFCAFEF00D; dws = 8'hFF;
    step();
    dwen = 0; iv = 1; ia = 64'h100;
    step();
    dv = 0; ia = 64'h104;
    step();
    iv = 0; dv = 1; dwen = 1; dwd = 64'h0; rst_n = 0;
    #1;
    chk("t6_ready_low_in_reset", drdy_c, 0);
    step();
    rst_n = 1; dv = 0; dwen = 0;
    #1;
    chk("t6_rd_cnt_cleared", rdc_c, 0);
    chk("t6_wr_cnt_cleared", wrc_c, 0);
    dv = 1; da = 64'h100; iv = 1; ia = 64'h104;
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("t6_no_irsp_%0d", j), irv_c, 0);
      chk($sformatf("t6_no_drsp_%0d", j), drv_c, 0);
      step();
      dv = 0; iv = 0;
    end
    chk("t6_irsp_valid", irv_c, 1);
    chk("t6_irsp_data", ird_c, 32'hDEADBEEF);
    chk("t6_drsp_valid", drv_c, 1);
    chk("t6_drsp_data", drd_c, 64'hDEADBEEFCAFEF00D);
    step();
    chk("t6_irsp_drop", irv_c, 0);
    chk("t6_drsp_drop", drv_c, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
